// File: rtl/dmem_arbiter.sv
// Arbiter/sequencer for the single-port data RAM shared by the CPU MEM stage and the debug port.
// Each access takes one RAM-driving cycle plus one completion cycle; CPU wins ties up to a burst limit.
module dmem_arbiter #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned CPU_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [31:0]       dbg_wdata,
    output logic [31:0]       dbg_rdata,
    output logic              dbg_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_din,
    output logic              ram_str,
    output logic              ram_ld,
    input  logic [31:0]       ram_dout
);
    localparam int unsigned RunW = $clog2(CPU_BURST + 1);

    typedef enum logic [1:0] {StIdle, StAcc, StResp} state_e;
    typedef enum logic {OwnCpu, OwnDbg} owner_e;

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [RunW-1:0]   run_q, run_d;
    logic [31:0]       cpu_rdata_q, cpu_rdata_d;
    logic [31:0]       dbg_rdata_q, dbg_rdata_d;

    logic              acc;
    logic              cpu_owns;
    logic              cpu_elig;
    logic              dbg_elig;
    logic              grant_dbg;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic              sel_we;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0]};

    assign acc      = (state_q == StAcc);
    assign cpu_owns = (owner_q == OwnCpu);

    // The port completing this cycle may not be re-granted back-to-back.
    assign cpu_elig  = cpu_req & !((state_q == StResp) && cpu_owns);
    assign dbg_elig  = dbg_req & !((state_q == StResp) && !cpu_owns);
    assign grant_dbg = dbg_elig & (!cpu_elig | (run_q == RunW'(CPU_BURST)));

    assign sel_addr  = cpu_owns ? cpu_addr[ADDR_W+1:2] : dbg_addr;
    assign sel_wdata = cpu_owns ? cpu_wdata : dbg_wdata;
    assign sel_we    = cpu_owns ? cpu_we : dbg_we;

    assign ram_addr  = acc ? sel_addr : '0;
    assign ram_din   = acc ? sel_wdata : '0;
    assign ram_str   = acc & sel_we;
    assign ram_ld    = acc & !sel_we;

    assign cpu_done  = (state_q == StResp) & cpu_owns;
    assign dbg_ack   = (state_q == StResp) & !cpu_owns;
    assign cpu_stall = cpu_req & !cpu_done;
    assign cpu_rdata = cpu_rdata_q;
    assign dbg_rdata = dbg_rdata_q;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        run_d       = run_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        unique case (state_q)
            StAcc: begin
                state_d = StResp;
                if (!sel_we) begin
                    if (cpu_owns) cpu_rdata_d = ram_dout;
                    else          dbg_rdata_d = ram_dout;
                end
            end
            StIdle, StResp: begin
                if (grant_dbg) begin
                    state_d = StAcc;
                    owner_d = OwnDbg;
                    run_d   = '0;
                end else if (cpu_elig) begin
                    state_d = StAcc;
                    owner_d = OwnCpu;
                    // Count CPU grants only while DBG is actually waiting.
                    run_d   = dbg_req ? run_q + RunW'(1) : '0;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            owner_q     <= OwnCpu;
            run_q       <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            run_q       <= run_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic, every cycle checked against
// a transaction-level model (who occupies the RAM, who completes, shadow memory).
module tb_dmem_arbiter;
    localparam int ADDR_W    = 10;
    localparam int CPU_BURST = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_done, cpu_stall;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dbg_req, dbg_we, dbg_ack;
    logic [ADDR_W-1:0] dbg_addr;
    logic [31:0] dbg_wdata, dbg_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0] ram_din, ram_dout;
    logic        ram_str, ram_ld;

    dmem_arbiter #(.ADDR_W(ADDR_W), .CPU_BURST(CPU_BURST)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_str(ram_str), .ram_ld(ram_ld),
        .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // RAM: combinational read, write on rising edge; preload port used only during reset.
    logic [31:0] ram [1024];
    logic        pre_en;
    logic [9:0]  pre_a;
    logic [31:0] pre_d;
    assign ram_dout = ram[ram_addr];
    always @(posedge clk) begin
        if (ram_str)     ram[ram_addr] <= ram_din;
        else if (pre_en) ram[pre_a] <= pre_d;
    end

    // Model: m_acc = port occupying the RAM this cycle, m_done = port completing (-1 none,
    // 0 CPU, 1 DBG); m_streak = CPU grants since DBG last got in while DBG was waiting.
    int          m_acc, m_done, m_streak;
    logic [31:0] m_cpu_rd, m_dbg_rd;
    logic [31:0] shadow [1024];

    int checks, fails;

    logic        s_done, s_ack, s_stall, s_str, s_ld;
    logic [9:0]  s_addr;
    logic [31:0] s_cpu_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_acc = -1; m_done = -1; m_streak = 0;
        m_cpu_rd = '0; m_dbg_rd = '0;
    endtask

    task automatic preload(input int a, input logic [31:0] d);
        pre_a = 10'(a); pre_d = d; pre_en = 1'b1;
        @(posedge clk); #1;
        pre_en = 1'b0;
        shadow[a] = d;
    endtask

    // One clock: check outputs at the falling edge, advance the model, return 1 after rising edge.
    task automatic step();
        logic [9:0]  ea;
        logic [31:0] ed;
        logic        es, el, wc, wd;
        @(negedge clk);
        ea = '0; ed = '0; es = 1'b0; el = 1'b0;
        if (m_acc == 0) begin
            ea = cpu_addr[11:2]; ed = cpu_wdata; es = cpu_we; el = !cpu_we;
        end else if (m_acc == 1) begin
            ea = dbg_addr; ed = dbg_wdata; es = dbg_we; el = !dbg_we;
        end
        s_done = cpu_done; s_ack = dbg_ack; s_stall = cpu_stall;
        s_str = ram_str; s_ld = ram_ld; s_addr = ram_addr; s_cpu_rdata = cpu_rdata;
        chk("ram_addr", 32'(ram_addr), 32'(ea));
        chk("ram_din", ram_din, ed);
        chk("ram_str", 32'(ram_str), 32'(es));
        chk("ram_ld", 32'(ram_ld), 32'(el));
        chk("cpu_done", 32'(cpu_done), 32'(m_done == 0));
        chk("dbg_ack", 32'(dbg_ack), 32'(m_done == 1));
        chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req && m_done != 0));
        chk("cpu_rdata", cpu_rdata, m_cpu_rd);
        chk("dbg_rdata", dbg_rdata, m_dbg_rd);
        if (rst) begin
            model_reset();
        end else if (m_acc >= 0) begin
            if (es)              shadow[ea] = ed;
            else if (m_acc == 0) m_cpu_rd = shadow[ea];
            else                 m_dbg_rd = shadow[ea];
            m_done = m_acc;
            m_acc  = -1;
        end else begin
            wc = cpu_req && m_done != 0;
            wd = dbg_req && m_done != 1;
            m_done = -1;
            if (wd && (!wc || m_streak == CPU_BURST)) begin
                m_acc = 1; m_streak = 0;
            end else if (wc) begin
                m_acc = 0; m_streak = dbg_req ? m_streak + 1 : 0;
            end
        end
        @(posedge clk); #1;
    endtask

    int run_cnt, max_run, ack_cnt;

    initial begin
        checks = 0; fails = 0;
        model_reset();
        rst = 1'b1; pre_en = 1'b0; pre_a = '0; pre_d = '0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
        #2;
        for (int i = 0; i < 16; i++) preload(i, $urandom);
        preload(5, 32'hDEADBEEF);
        step();
        rst = 1'b0;

        // CPU read alone
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h14;
        step();
        chk("t1_stall_req", 32'(s_stall), 1);
        step();
        chk("t1_acc_addr", 32'(s_addr), 5);
        chk("t1_acc_ld", 32'(s_ld), 1);
        chk("t1_stall_acc", 32'(s_stall), 1);
        step();
        chk("t1_done", 32'(s_done), 1);
        chk("t1_rdata", s_cpu_rdata, 32'hDEADBEEF);
        chk("t1_stall_resp", 32'(s_stall), 0);
        cpu_req = 0;
        step();

        // DBG write then CPU read of the same word
        dbg_req = 1; dbg_we = 1; dbg_addr = 10'd7; dbg_wdata = 32'h12345678;
        step(); step(); step();
        chk("t2_ack", 32'(s_ack), 1);
        dbg_req = 0; dbg_we = 0;
        step();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h1C;
        step(); step(); step();
        chk("t2_rdata", s_cpu_rdata, 32'h12345678);
        cpu_req = 0;
        step();

        // Simultaneous requests: CPU first, DBG straight after CPU completion
        cpu_req = 1; cpu_addr = 32'h0; dbg_req = 1; dbg_addr = 10'd1;
        step();
        step();
        chk("t3_cpu_first", 32'(s_addr), 0);
        step();
        chk("t3_cpu_done", 32'(s_done), 1);
        cpu_req = 0;
        step();
        chk("t3_dbg_acc_ld", 32'(s_ld), 1);
        chk("t3_dbg_acc_addr", 32'(s_addr), 1);
        step();
        chk("t3_dbg_ack", 32'(s_ack), 1);
        dbg_req = 0;
        step();

        // High and misaligned address bits are ignored
        cpu_req = 1; cpu_addr = 32'hFFFF_F017;
        step(); step();
        chk("t5_addr", 32'(s_addr), 5);
        step();
        chk("t5_rdata", s_cpu_rdata, 32'hDEADBEEF);
        cpu_req = 0;
        step();

        // Both ports requesting continuously: DBG must get in within CPU_BURST CPU accesses
        run_cnt = 0; max_run = 0; ack_cnt = 0;
        cpu_req = 1; dbg_req = 1;
        for (int i = 0; i < 40; i++) begin
            cpu_addr = 32'($urandom_range(0, 15)) << 2;
            dbg_addr = 10'($urandom_range(0, 15));
            step();
            if (s_done) begin
                run_cnt++;
                if (run_cnt > max_run) max_run = run_cnt;
            end
            if (s_ack) begin
                ack_cnt++;
                run_cnt = 0;
            end
        end
        chk("t4_burst_bound", 32'(max_run <= CPU_BURST), 1);
        chk("t4_dbg_served", 32'(ack_cnt >= 5), 1);
        cpu_req = 0; dbg_req = 0;
        step(); step(); step();

        // Reset during a CPU write access
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h30; cpu_wdata = 32'hCAFEF00D;
        step();
        #1;
        chk("t6_str_before", 32'(ram_str), 1);
        #1 rst = 1'b1;
        #1;
        chk("t6_str_killed", 32'(ram_str), 0);
        chk("t6_ld", 32'(ram_ld), 0);
        chk("t6_addr", 32'(ram_addr), 0);
        chk("t6_din", ram_din, 0);
        chk("t6_done", 32'(cpu_done), 0);
        chk("t6_ack", 32'(dbg_ack), 0);
        chk("t6_cpu_rdata", cpu_rdata, 0);
        chk("t6_dbg_rdata", dbg_rdata, 0);
        chk("t6_stall", 32'(cpu_stall), 1);
        model_reset();
        step();
        rst = 1'b0; cpu_req = 0; cpu_we = 0;
        step();

        // Random traffic, including request drops at arbitrary times
        for (int i = 0; i < 600; i++) begin
            cpu_req   = ($urandom_range(0, 9) < 6);
            cpu_we    = $urandom_range(0, 1) == 1;
            cpu_addr  = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
            cpu_wdata = $urandom;
            dbg_req   = ($urandom_range(0, 9) < 5);
            dbg_we    = $urandom_range(0, 1) == 1;
            dbg_addr  = 10'($urandom_range(0, 15));
            dbg_wdata = $urandom;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
